// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU and load-unit results onto one register-file
// write port and keeps the per-register busy scoreboard used by decode.
module wb_stage #(
   parameter int REGS_PTR_W = 5,
   parameter int REGS_NUM   = 32,
   parameter int REG_SIZE   = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iss_vld,
   input  logic [REGS_PTR_W-1:0] iss_rd,
   output logic                  iss_busy,
   input  logic [REGS_PTR_W-1:0] q_rs1,
   input  logic [REGS_PTR_W-1:0] q_rs2,
   output logic                  q_busy1,
   output logic                  q_busy2,
   input  logic                  alu_vld,
   input  logic [REGS_PTR_W-1:0] alu_rd,
   input  logic [REG_SIZE-1:0]   alu_data,
   output logic                  alu_rdy,
   input  logic                  mem_vld,
   input  logic [REGS_PTR_W-1:0] mem_rd,
   input  logic [REG_SIZE-1:0]   mem_data,
   output logic                  mem_rdy,
   output logic                  we,
   output logic [REGS_PTR_W-1:0] wa,
   output logic [REG_SIZE-1:0]   wd
);
   localparam int                    STV_W     = $clog2(STARVE_MAX + 1);
   localparam logic [STV_W-1:0]      STV_LIMIT = STV_W'(STARVE_MAX);
   localparam logic [STV_W-1:0]      STV_ZERO  = {STV_W{1'b0}};
   localparam logic [REGS_PTR_W-1:0] RD_ZERO   = {REGS_PTR_W{1'b0}};
   localparam logic [REG_SIZE-1:0]   DATA_ZERO = {REG_SIZE{1'b0}};
   localparam logic [REGS_NUM-1:0]   SB_ZERO   = {REGS_NUM{1'b0}};

   logic                  r_alu_v;
   logic [REGS_PTR_W-1:0] r_alu_rd;
   logic [REG_SIZE-1:0]   r_alu_d;
   logic                  r_mem_v;
   logic [REGS_PTR_W-1:0] r_mem_rd;
   logic [REG_SIZE-1:0]   r_mem_d;
   logic [STV_W-1:0]      r_starve;
   logic [REGS_NUM-1:0]   r_sb;
   logic                  r_we;
   logic [REGS_PTR_W-1:0] r_wa;
   logic [REG_SIZE-1:0]   r_wd;

   logic                  w_alu_gnt;
   logic                  w_mem_gnt;
   logic                  w_gnt;
   logic [REGS_PTR_W-1:0] w_gnt_rd;
   logic [REG_SIZE-1:0]   w_gnt_d;
   logic                  w_alu_acc;
   logic                  w_mem_acc;
   logic [REGS_NUM-1:0]   w_sb_nxt;

   function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
      if (v == STV_LIMIT) begin
         return v;
      end else begin
         return v + STV_W'(1);
      end
   endfunction

   // MEM has priority until ALU has waited STARVE_MAX consecutive MEM grants
   assign w_alu_gnt = r_alu_v & (~r_mem_v | (r_starve == STV_LIMIT));
   assign w_mem_gnt = r_mem_v & ~w_alu_gnt;
   assign w_gnt     = w_alu_gnt | w_mem_gnt;
   assign w_gnt_rd  = w_alu_gnt ? r_alu_rd : r_mem_rd;
   assign w_gnt_d   = w_alu_gnt ? r_alu_d  : r_mem_d;

   assign alu_rdy   = (~r_alu_v | w_alu_gnt) & rst_n;
   assign mem_rdy   = (~r_mem_v | w_mem_gnt) & rst_n;
   assign w_alu_acc = alu_vld & alu_rdy;
   assign w_mem_acc = mem_vld & mem_rdy;

   assign iss_busy  = r_sb[iss_rd];
   assign q_busy1   = r_sb[q_rs1];
   assign q_busy2   = r_sb[q_rs2];

   assign we        = r_we;
   assign wa        = r_wa;
   assign wd        = r_wd;

   // Scoreboard next state: clear applied first so a same-edge issue wins
   always_comb begin
      w_sb_nxt = r_sb;
      if (w_gnt) begin
         w_sb_nxt[w_gnt_rd] = 1'b0;
      end else begin
         w_sb_nxt = r_sb;
      end
      if (iss_vld && (iss_rd != RD_ZERO)) begin
         w_sb_nxt[iss_rd] = 1'b1;
      end else begin
         w_sb_nxt[0] = 1'b0;
      end
      w_sb_nxt[0] = 1'b0;
   end

   // ALU holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_v  <= 1'b0;
         r_alu_rd <= RD_ZERO;
         r_alu_d  <= DATA_ZERO;
      end else if (w_alu_acc && (alu_rd != RD_ZERO)) begin
         r_alu_v  <= 1'b1;
         r_alu_rd <= alu_rd;
         r_alu_d  <= alu_data;
      end else if (w_alu_gnt) begin
         r_alu_v  <= 1'b0;
      end else begin
         r_alu_v  <= r_alu_v;
      end
   end

   // MEM holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_v  <= 1'b0;
         r_mem_rd <= RD_ZERO;
         r_mem_d  <= DATA_ZERO;
      end else if (w_mem_acc && (mem_rd != RD_ZERO)) begin
         r_mem_v  <= 1'b1;
         r_mem_rd <= mem_rd;
         r_mem_d  <= mem_data;
      end else if (w_mem_gnt) begin
         r_mem_v  <= 1'b0;
      end else begin
         r_mem_v  <= r_mem_v;
      end
   end

   // Starve counter tracks MEM wins while an ALU result is waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= STV_ZERO;
      end else if (!r_alu_v || w_alu_gnt) begin
         r_starve <= STV_ZERO;
      end else if (w_mem_gnt) begin
         r_starve <= sat_inc(r_starve);
      end else begin
         r_starve <= r_starve;
      end
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sb <= SB_ZERO;
      end else begin
         r_sb <= w_sb_nxt;
      end
   end

   // Register-file write port; address and data persist when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we <= 1'b0;
         r_wa <= RD_ZERO;
         r_wd <= DATA_ZERO;
      end else if (w_gnt) begin
         r_we <= 1'b1;
         r_wa <= w_gnt_rd;
         r_wd <= w_gnt_d;
      end else begin
         r_we <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic against an
// abstract model of the two result slots, arbitration and busy bits.
module tb_wb_stage;
   localparam int PW = 5;
   localparam int NR = 32;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          iss_vld;
   logic [PW-1:0] iss_rd;
   logic          iss_busy;
   logic [PW-1:0] q_rs1;
   logic [PW-1:0] q_rs2;
   logic          q_busy1;
   logic          q_busy2;
   logic          alu_vld;
   logic [PW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_rdy;
   logic          mem_vld;
   logic [PW-1:0] mem_rd;
   logic [DW-1:0] mem_data;
   logic          mem_rdy;
   logic          we;
   logic [PW-1:0] wa;
   logic [DW-1:0] wd;

   int checks = 0;
   int fails  = 0;

   // reference model state
   logic          m_av = 1'b0;
   logic          m_mv = 1'b0;
   logic [PW-1:0] m_ard = '0;
   logic [PW-1:0] m_mrd = '0;
   logic [DW-1:0] m_ad = '0;
   logic [DW-1:0] m_md = '0;
   int            m_starve = 0;
   logic [NR-1:0] m_sb = '0;
   logic          e_we = 1'b0;
   logic [PW-1:0] e_wa = '0;
   logic [DW-1:0] e_wd = '0;

   wb_stage #(.REGS_PTR_W(PW), .REGS_NUM(NR), .REG_SIZE(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .iss_vld(iss_vld), .iss_rd(iss_rd), .iss_busy(iss_busy),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
      .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_data(alu_data), .alu_rdy(alu_rdy),
      .mem_vld(mem_vld), .mem_rd(mem_rd), .mem_data(mem_data), .mem_rdy(mem_rdy),
      .we(we), .wa(wa), .wd(wd)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic alu_wins();
      return m_av && (!m_mv || (m_starve == SM));
   endfunction

   function automatic logic mem_wins();
      return m_mv && !alu_wins();
   endfunction

   // model: one result slot per source, one write per cycle
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_av = 1'b0; m_mv = 1'b0; m_starve = 0; m_sb = '0;
            e_we = 1'b0; e_wa = '0; e_wd = '0;
         end else begin
            logic ag, mg, aacc, macc;
            ag   = alu_wins();
            mg   = mem_wins();
            aacc = alu_vld && (!m_av || ag);
            macc = mem_vld && (!m_mv || mg);
            if (!m_av || ag) m_starve = 0;
            else if (mg && m_starve < SM) m_starve = m_starve + 1;
            if (ag) begin
               e_we = 1'b1; e_wa = m_ard; e_wd = m_ad; m_sb[m_ard] = 1'b0; m_av = 1'b0;
            end else if (mg) begin
               e_we = 1'b1; e_wa = m_mrd; e_wd = m_md; m_sb[m_mrd] = 1'b0; m_mv = 1'b0;
            end else begin
               e_we = 1'b0;
            end
            if (aacc && alu_rd != 0) begin m_av = 1'b1; m_ard = alu_rd; m_ad = alu_data; end
            if (macc && mem_rd != 0) begin m_mv = 1'b1; m_mrd = mem_rd; m_md = mem_data; end
            if (iss_vld && iss_rd != 0) m_sb[iss_rd] = 1'b1;
         end
      end
   end

   // compare DUT to model on every falling edge
   initial begin
      forever begin
         @(negedge clk);
         cmp("alu_rdy", 32'(alu_rdy), 32'(rst_n && (!m_av || alu_wins())));
         cmp("mem_rdy", 32'(mem_rdy), 32'(rst_n && (!m_mv || mem_wins())));
         cmp("iss_busy", 32'(iss_busy), 32'(m_sb[iss_rd]));
         cmp("q_busy1", 32'(q_busy1), 32'(m_sb[q_rs1]));
         cmp("q_busy2", 32'(q_busy2), 32'(m_sb[q_rs2]));
         cmp("we", 32'(we), 32'(e_we));
         cmp("wa", 32'(wa), 32'(e_wa));
         cmp("wd", wd, e_wd);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_vld = 1'b0; alu_vld = 1'b0; mem_vld = 1'b0;
   endtask

   initial begin
      int wlog[$];
      int acc, wr, nw;
      rst_n = 1'b0; iss_vld = 1'b0; iss_rd = '0; q_rs1 = '0; q_rs2 = '0;
      alu_vld = 1'b0; alu_rd = '0; alu_data = '0;
      mem_vld = 1'b0; mem_rd = '0; mem_data = '0;
      repeat (2) @(negedge clk);
      cmp("rst_we", 32'(we), 32'd0);
      cmp("rst_alu_rdy", 32'(alu_rdy), 32'd0);
      cmp("rst_mem_rdy", 32'(mem_rdy), 32'd0);
      #2 rst_n = 1'b1;
      nxt();
      @(negedge clk);
      cmp("rel_alu_rdy", 32'(alu_rdy), 32'd1);
      cmp("rel_mem_rdy", 32'(mem_rdy), 32'd1);
      cmp("rel_busy", 32'({iss_busy, q_busy1, q_busy2}), 32'd0);
      nxt();

      // issue r5, ALU writes it back
      iss_vld = 1'b1; iss_rd = 5'd5; q_rs1 = 5'd5; nxt();
      iss_vld = 1'b0; alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5A5A5;
      @(negedge clk); cmp("r5_busy_a", 32'(q_busy1), 32'd1); nxt();
      alu_vld = 1'b0;
      @(negedge clk); cmp("r5_busy_b", 32'(q_busy1), 32'd1); cmp("r5_we_early", 32'(we), 32'd0); nxt();
      @(negedge clk);
      cmp("r5_we", 32'(we), 32'd1); cmp("r5_wa", 32'(wa), 32'd5);
      cmp("r5_wd", wd, 32'hA5A5A5A5); cmp("r5_busy_clr", 32'(q_busy1), 32'd0);
      nxt();

      // both sources offer for 12 cycles
      acc = 0; wr = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 12) begin
            alu_vld = 1'b1; alu_rd = 5'(1 + i); alu_data = $urandom;
            mem_vld = 1'b1; mem_rd = 5'(16 + i); mem_data = $urandom;
         end else begin
            idle();
         end
         @(negedge clk);
         if (alu_vld && alu_rdy) acc++;
         if (mem_vld && mem_rdy) acc++;
         if (we) begin wr++; wlog.push_back(int'(wa >= 5'd16)); end
         nxt();
      end
      cmp("burst_count", 32'(wr), 32'(acc));
      cmp("burst_len", 32'(wlog.size() >= 10), 32'd1);
      for (int k = 0; k < 10 && k < wlog.size(); k++)
         cmp("burst_pattern", 32'(wlog[k]), 32'((k % 5) != 4));

      // MEM result to r0 is dropped
      mem_vld = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF; q_rs1 = 5'd0;
      @(negedge clk); cmp("r0_mem_rdy", 32'(mem_rdy), 32'd1); cmp("r0_busy", 32'(q_busy1), 32'd0); nxt();
      mem_vld = 1'b0;
      repeat (3) begin @(negedge clk); cmp("r0_no_we", 32'(we), 32'd0); nxt(); end

      // re-issue r7 on the edge that writes r7 back
      iss_vld = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7; nxt();
      iss_vld = 1'b0; alu_vld = 1'b1; alu_rd = 5'd7; alu_data = $urandom; nxt();
      alu_vld = 1'b0; iss_vld = 1'b1; iss_rd = 5'd7; nxt();
      iss_vld = 1'b0;
      @(negedge clk);
      cmp("r7_we", 32'(we), 32'd1); cmp("r7_wa", 32'(wa), 32'd7); cmp("r7_busy", 32'(q_busy1), 32'd1);
      nxt();

      // reset pulse with both slots full and r3/r9 busy
      iss_vld = 1'b1; iss_rd = 5'd3; nxt();
      iss_rd = 5'd9; nxt();
      iss_vld = 1'b0;
      alu_vld = 1'b1; alu_rd = 5'd10; alu_data = $urandom;
      mem_vld = 1'b1; mem_rd = 5'd11; mem_data = $urandom; nxt();
      alu_vld = 1'b0; mem_rd = 5'd12; nxt();
      mem_vld = 1'b0; q_rs1 = 5'd3; q_rs2 = 5'd9; iss_rd = 5'd3;
      #1;
      cmp("pre_rst_we", 32'(we), 32'd1);
      cmp("pre_rst_busy", 32'({q_busy1, q_busy2}), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      cmp("arst_we", 32'(we), 32'd0);
      cmp("arst_rdy", 32'({alu_rdy, mem_rdy}), 32'd0);
      cmp("arst_busy", 32'({iss_busy, q_busy1, q_busy2}), 32'd0);
      #8 rst_n = 1'b1;
      nxt();
      nw = 0;
      repeat (6) begin @(negedge clk); if (we) nw++; nxt(); end
      cmp("no_write_after_rst", 32'(nw), 32'd0);

      // ALU alone, back-to-back for 8 cycles
      for (int i = 0; i < 12; i++) begin
         alu_vld = (i < 8); alu_rd = 5'(i + 1); alu_data = $urandom;
         @(negedge clk);
         if (i < 8) cmp("b2b_rdy", 32'(alu_rdy), 32'd1);
         cmp("b2b_we", 32'(we), 32'((i >= 2) && (i <= 9)));
         nxt();
      end

      // random traffic
      acc = 0; wr = 0;
      for (int i = 0; i < 600; i++) begin
         if (i < 590) begin
            alu_vld = ($urandom_range(0, 99) < 70); alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
            mem_vld = ($urandom_range(0, 99) < 70); mem_rd = 5'($urandom_range(0, 31)); mem_data = $urandom;
            iss_vld = ($urandom_range(0, 99) < 30); iss_rd = 5'($urandom_range(0, 31));
         end else begin
            idle();
         end
         q_rs1 = 5'($urandom_range(0, 31)); q_rs2 = 5'($urandom_range(0, 31));
         @(negedge clk);
         if (alu_vld && alu_rdy && alu_rd != 0) acc++;
         if (mem_vld && mem_rdy && mem_rd != 0) acc++;
         if (we) wr++;
         nxt();
      end
      cmp("rand_count", 32'(wr), 32'(acc));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter REGS_PTR_W, default 5, register pointer width in bits.
REQ-002 The block SHALL have parameter REGS_NUM, default 32, number of architectural registers and scoreboard bits.
REQ-003 The block SHALL have parameter REG_SIZE, default 32, data width in bits.
REQ-004 The block SHALL have parameter STARVE_MAX, default 4, the number of consecutive MEM grants allowed while ALU waits.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 iss_vld  input  1  an instruction with destination iss_rd issues this cycle.
REQ-008 iss_rd  input  REGS_PTR_W  destination register of the issuing instruction.
REQ-009 iss_busy  output  1  combinational: scoreboard bit of iss_rd.
REQ-010 q_rs1, q_rs2  input  REGS_PTR_W each  source registers queried by decode.
REQ-011 q_busy1, q_busy2  output  1 each  combinational: scoreboard bits of q_rs1 and q_rs2.
REQ-012 alu_vld, alu_rd, alu_data  input  1 / REGS_PTR_W / REG_SIZE  ALU result offer.
REQ-013 alu_rdy  output  1  ALU result accepted when alu_vld & alu_rdy at a rising edge.
REQ-014 mem_vld, mem_rd, mem_data  input  1 / REGS_PTR_W / REG_SIZE  load-unit result offer.
REQ-015 mem_rdy  output  1  MEM result accepted when mem_vld & mem_rdy at a rising edge.
REQ-016 we, wa, wd  output  1 / REGS_PTR_W / REG_SIZE  registered register-file write port.

Function
REQ-017 Each source (ALU, MEM) SHALL have a one-entry holding register (valid, rd, data).
REQ-018 An accepted result with rd != 0 SHALL load its holding register; an accepted result with rd == 0 SHALL be discarded (handshake completes, no holding entry, no write).
REQ-019 Grant: when both holds are valid, MEM wins unless the starve counter equals STARVE_MAX, in which case ALU wins; when one hold is valid it wins; at most one grant per cycle.
REQ-020 Starve counter: increment (saturating at STARVE_MAX) on a MEM grant while the ALU hold is valid; clear on any ALU grant or when the ALU hold is empty.
REQ-021 On a grant, the next rising edge SHALL load we=1, wa=held rd, wd=held data, and SHALL clear the granted hold unless refilled at the same edge.
REQ-022 With no grant, the next edge SHALL load we=0; wa and wd SHALL hold their previous values.
REQ-023 alu_rdy SHALL equal (!alu_hold_valid | alu_grant) & rst_n, and mem_rdy likewise, giving one accept per cycle per source with no bubble.
REQ-024 Latency: a result accepted at edge E0 SHALL drive we=1 no earlier than the cycle after edge E1 (two edges after acceptance when uncontended).
REQ-025 Scoreboard: REGS_NUM bits; bit 0 SHALL be constant 0.
REQ-026 Scoreboard set: iss_vld & iss_rd != 0 SHALL set bit iss_rd at the edge.
REQ-027 Scoreboard clear: a grant SHALL clear bit wa at the same edge that loads we=1.
REQ-028 When a set and a clear hit the same bit at one edge, the set SHALL win.
REQ-029 An issue to an already-set bit leaves it set; the first writeback to that register clears it (decode stalls on iss_busy; WAW depth is not tracked).
REQ-030 Query outputs SHALL reflect the registered scoreboard only, with no same-cycle bypass of issue or grant.

Reset
REQ-031 While rst_n=0: we=0, wa=0, wd=0, both holds empty, starve counter=0, scoreboard all 0, alu_rdy=0, mem_rdy=0.
REQ-032 Reset assertion mid-operation SHALL discard held results and scoreboard state immediately, without waiting for a clock edge.
REQ-033 On the first cycle after release: alu_rdy=1, mem_rdy=1, and all busy outputs are 0.

Verification
REQ-034 Issue rd=5, then ALU offers rd=5 data=0xA5A5A5A5 -> q_busy1(rs1=5)=1 until the edge where we=1, wa=5, wd=0xA5A5A5A5, then 0.
REQ-035 ALU and MEM both offer every cycle for 12 cycles -> grants follow the pattern MEM x4, ALU x1, repeating; no result is lost; the per-cycle we count equals the accept count.
REQ-036 MEM offers rd=0 data=0xFFFFFFFF -> mem_rdy=1, the handshake completes, we is never asserted, and the scoreboard is unchanged.
REQ-037 Issue rd=7 at the same edge that writeback of rd=7 is granted -> bit 7 remains 1 afterwards.
REQ-038 Pulse rst_n low while both holds are full and bits 3 and 9 are set -> we=0, rdy=0, and busy=0 immediately; no write of the held data occurs after release.
REQ-039 ALU alone offers back-to-back for 8 cycles -> alu_rdy stays 1 and we=1 for 8 consecutive cycles, starting two edges after the first accept.
